seg7_scan: RTL and testbench

Eight-digit multiplexed hexadecimal display driver that consumes the 32-bit register value exported by the CPU top level (`x3`) and drives a common-anode 7-segment bank on the board. It samples the value on the board clock, admits a new value only when it is stable, and holds it for a full frame. It scans digits with an inter-digit blanking gap, suppresses leading zeros and flags value changes on the decimal point.

---
 rtl/seg7_scan.sv | 143 ++++++++++++++
 tb/tb_seg7_scan.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed hex display driver for a common-anode 7-segment bank.
// A new value is admitted only at a frame boundary, and only if it was stable on the two cycles before it.
module seg7_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int BLANK_LZ  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    dig;
  logic [31:0]   v1;
  logic [31:0]   v2;
  logic [31:0]   shadow;
  logic          chg;

  logic [3:0]    nibble;
  logic [31:0]   upper;
  logic          dark;
  logic [6:0]    glyph;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b1111111;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // The frame pulse marks the load point; a value that moved on the previous cycle is rejected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1     <= 32'd0;
      v2     <= 32'd0;
      shadow <= 32'd0;
      chg    <= 1'b0;
    end else begin
      v1 <= value;
      v2 <= v1;
      if (frame) begin
        if (v1 == v2) begin
          shadow <= v2;
          chg    <= (v2 != shadow);
        end else begin
          chg <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    nibble = shadow[{dig, 2'b00} +: 4];
    upper  = shadow >> {dig, 2'b00};
    dark   = (BLANK_LZ != 0) && (dig != 3'd0) && (upper == 32'd0);
    glyph  = hex7(nibble);
  end

  // Outputs are registered from the current state/counter, so they trail them by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BLANK;
      cnt   <= '0;
      dig   <= 3'd0;
      an    <= 8'hFF;
      seg   <= 7'h7F;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      frame <= (dig == 3'd7) && (cnt == CNT_LAST);
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        dig <= dig + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        BLANK: begin
          an  <= 8'hFF;
          seg <= 7'h7F;
          dp  <= 1'b1;
          if (cnt == BLANK_LAST) begin
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (dark) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
          end else begin
            an  <= ~(8'd1 << dig);
            seg <= glyph;
          end
          dp <= ~((dig == 3'd0) && chg);
          if (cnt == CNT_LAST) begin
            state <= BLANK;
          end
        end
        default: begin
          state <= BLANK;
          an    <= 8'hFF;
          seg   <= 7'h7F;
          dp    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with a short scan period; one instance blanks leading zeros, one shows all digits.
module tb_seg7_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;
  logic [7:0]  an_full;
  logic [6:0]  seg_full;
  logic        dp_full;
  logic        frame_full;

  int check_count = 0;
  int pass_count  = 0;

  logic [6:0] hex_table [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .value(value), .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLANK_LZ(0)) dut_full (
    .clk(clk), .rst(rst), .value(value), .an(an_full), .seg(seg_full), .dp(dp_full),
    .frame(frame_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] v);
    value = v;
  endtask

  // Called just after reset release; the first frame pulse must land 32 cycles later.
  task automatic countToFrame();
    int k;
    k = 0;
    while (k < 40) begin
      tick();
      k++;
      if (frame === 1'b1) break;
    end
    checkOutput("first_frame_delay", k, 32);
  endtask

  // Starts on a frame cycle and walks one whole frame, ending on the next frame cycle.
  task automatic scanFrame(input logic [31:0] shown, input logic chg_exp, input int set_at,
                           input logic [31:0] set_val);
    int         d;
    int         ph;
    logic [3:0] nib;
    logic       dark;
    logic [7:0] an_full_exp;
    logic [6:0] seg_full_exp;
    logic       dp_exp;
    for (int t = 1; t <= 32; t++) begin
      tick();
      d    = (t - 1) / 4;
      ph   = (t - 1) % 4;
      nib  = shown[d*4 +: 4];
      dark = (d > 0) && ((shown >> (d*4)) == 32'd0);
      if (ph == 0) begin
        an_full_exp  = 8'hFF;
        seg_full_exp = 7'h7F;
        dp_exp       = 1'b1;
      end else begin
        an_full_exp  = ~(8'd1 << d);
        seg_full_exp = hex_table[nib];
        dp_exp       = !((d == 0) && chg_exp);
      end
      checkOutput($sformatf("an d%0d p%0d val %h", d, ph, shown), an, dark ? 8'hFF : an_full_exp);
      checkOutput($sformatf("seg d%0d p%0d val %h", d, ph, shown), seg,
                  dark ? 7'h7F : seg_full_exp);
      checkOutput($sformatf("dp d%0d p%0d val %h", d, ph, shown), dp, dp_exp);
      checkOutput($sformatf("an_full d%0d p%0d", d, ph), an_full, an_full_exp);
      checkOutput($sformatf("seg_full d%0d p%0d", d, ph), seg_full, seg_full_exp);
      checkOutput($sformatf("dp_full d%0d p%0d", d, ph), dp_full, dp_exp);
      checkOutput($sformatf("frame t%0d", t), frame, (t == 32));
      if (t == set_at) applyStimulus(set_val);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(32'd0);
    repeat (3) tick();
    checkOutput("reset an", an, 8'hFF);
    checkOutput("reset seg", seg, 7'h7F);
    checkOutput("reset dp", dp, 1'b1);
    checkOutput("reset frame", frame, 1'b0);

    rst = 1'b1;
    countToFrame();

    // Value 0: only digit 0 lit, showing "0" with the decimal point off.
    repeat (2) tick();
    checkOutput("zero d0 an", an, 8'hFE);
    checkOutput("zero d0 seg", seg, 7'b1000000);
    checkOutput("zero d0 dp", dp, 1'b1);
    repeat (4) tick();
    checkOutput("zero d1 an dark", an, 8'hFF);
    checkOutput("zero d1 an_full", an_full, 8'hFD);
    checkOutput("zero d1 seg_full", seg_full, 7'b1000000);

    // Asynchronous reset in the middle of a driven digit.
    rst = 1'b0;
    #1;
    checkOutput("midreset an", an, 8'hFF);
    checkOutput("midreset an_full", an_full, 8'hFF);
    checkOutput("midreset seg_full", seg_full, 7'h7F);
    checkOutput("midreset dp", dp, 1'b1);
    checkOutput("midreset frame", frame, 1'b0);
    tick();
    rst = 1'b1;
    countToFrame();

    scanFrame(32'h0000_0000, 1'b0, 1, 32'h89AB_CDEF);
    scanFrame(32'h89AB_CDEF, 1'b1, -1, 32'd0);
    scanFrame(32'h89AB_CDEF, 1'b0, 1, 32'h0000_00A5);
    // Value moves on the cycle before the frame pulse, so that load is skipped.
    scanFrame(32'h0000_00A5, 1'b1, 31, 32'h0000_0000);
    scanFrame(32'h0000_00A5, 1'b0, -1, 32'd0);
    scanFrame(32'h0000_0000, 1'b1, -1, 32'd0);
    scanFrame(32'h0000_0000, 1'b0, -1, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
